// File: rtl/w80386_bus_pkg.sv
// Shared types and widths for the w80386 bus responder and its RAM.
package w80386_bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bus_responder_state_t;

endpackage

// File: rtl/w80386_bus_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The read register only moves on a read access, so it also serves as the held bus data.
module w80386_bus_ram
  import w80386_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      access,
  input  logic                      write_enable,
  input  logic                      clear_read,
  input  logic [ADDR_WIDTH-1:0]     index,
  input  logic [BUS_DATA_WIDTH-1:0] write_data,
  output logic [BUS_DATA_WIDTH-1:0] read_data
);

  logic [BUS_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clock) begin
    if (access && write_enable) begin
      mem[index] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      read_data <= '0;
    end else if (clear_read) begin
      read_data <= '0;
    end else if (access && !write_enable) begin
      read_data <= mem[index];
    end
  end

endmodule

// File: rtl/w80386_bus_responder.sv
// Memory target for the w80386 core bus with programmable wait states.
// Define W80386_BUS_RESPONDER_ERROR_EN to add the registered bus_error out-of-range flag.
module w80386_bus_responder
  import w80386_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      bus_vaild,
  output logic                      bus_ready,
  input  logic                      bus_write_enable,
  input  logic [BUS_ADDR_WIDTH-1:0] bus_address,
  input  logic [BUS_DATA_WIDTH-1:0] bus_write_data,
`ifdef W80386_BUS_RESPONDER_ERROR_EN
  output logic                      bus_error,
`endif
  output logic [BUS_DATA_WIDTH-1:0] bus_data
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  bus_responder_state_t state, next_state;
  logic [3:0]                count;
  logic                      req_write;
  logic [BUS_ADDR_WIDTH-1:0] req_address;
  logic [BUS_DATA_WIDTH-1:0] req_data;

  logic                      acc_write;
  logic [BUS_ADDR_WIDTH-1:0] acc_address;
  logic [BUS_DATA_WIDTH-1:0] acc_data;
  logic                      enter_ready;
  logic                      out_of_range;
  logic                      ready_q;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^bus_address[1:0];

  // NOTE: always_comb gives every output a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus_vaild) next_state = (WAIT_STATES == 0) ? READY : WAIT;
      WAIT: begin
        if (!bus_vaild)      next_state = IDLE;
        else if (count == 0) next_state = READY;
      end
      READY:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge, so use the live bus there.
  always_comb begin
    if (state == IDLE) begin
      acc_write   = bus_write_enable;
      acc_address = bus_address;
      acc_data    = bus_write_data;
    end else begin
      acc_write   = req_write;
      acc_address = req_address;
      acc_data    = req_data;
    end
  end

  // Gating with reset keeps a write from committing on the edge that resets the FSM.
  assign enter_ready  = reset && (next_state == READY);
  assign out_of_range = |(acc_address >> (ADDR_WIDTH + 2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      ready_q     <= 1'b0;
      req_write   <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
    end else begin
      state   <= next_state;
      ready_q <= enter_ready;
      if (state == IDLE && bus_vaild) begin
        req_write   <= bus_write_enable;
        req_address <= bus_address;
        req_data    <= bus_write_data;
        count       <= WAIT_LOAD;
      end else if (state == WAIT && count != 0) begin
        count <= count - 4'd1;
      end
    end
  end

  w80386_bus_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock        (clock),
    .reset        (reset),
    .access       (enter_ready && !out_of_range),
    .write_enable (acc_write),
    .clear_read   (enter_ready && out_of_range && !acc_write),
    .index        (acc_address[ADDR_WIDTH+1:2]),
    .write_data   (acc_data),
    .read_data    (bus_data)
  );

  assign bus_ready = ready_q;

`ifdef W80386_BUS_RESPONDER_ERROR_EN
  logic error_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= enter_ready && out_of_range;
    end
  end

  assign bus_error = error_q;
`endif

endmodule
